mem_sram_ctrl: RTL and testbench
================================

# mem_sram_ctrl

Sequencer for the MEM stage's data-memory access: converts one 32-bit load/store request into two 16-bit accesses on an external asynchronous SRAM. While an access is in flight it holds `ready` low, which the pipeline uses as its freeze for the PC and all stage registers, including MEM→WB. It sits between the MEM-stage request signals and the SRAM pins.

## Interface
- `WAIT_CYCLES`, default 1: SRAM cycles per half-word phase minus one; legal range ≥1.
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, default 18: SRAM half-word address width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: store request from MEM stage.
- `rd_en` in 1: load request from MEM stage.
- `address` in 32: byte address, taken from the ALU result.
- `write_data` in 32: store data.
- `read_data` out 32: load result; valid in DONE and held until the next read completes.
- `ready` out 1: low = freeze pipeline.
- `addr_err` out 1: out-of-range flag; only active with the check macro.
- `sram_addr` out SRAM_AW: SRAM address.
- `sram_dq_out` out 16: write data to the pad.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from the pad.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE, request seen (`wr_en` or `rd_en`):
  - Latch address, data and op; go to LOW.
  - `wr_en` wins if both are high.
- Address mapping: `word = (address − ADDR_BASE) >> 2`, truncated to SRAM_AW−1 bits. LOW uses `sram_addr = {word,0}` (bits 15:0); HIGH uses `{word,1}` (bits 31:16).
- LOW and HIGH each last WAIT_CYCLES+1 cycles, counted by a phase counter that clears on entry.
- Write phase:
  - `sram_dq_oe=1` and `sram_dq_out` = the selected half for the whole phase.
  - `sram_we_n=0` on phase cycles 0..WAIT_CYCLES−1.
  - `sram_we_n=1` on the last cycle, which is the address/data hold.
- Read phase: `sram_dq_oe=0`, `sram_we_n=1`; `sram_dq_in` is captured into the matching half of `read_data` on the last cycle of the phase.
- LOW → HIGH → DONE. DONE → IDLE unconditionally; the request still present in DONE is the completed one and is never restarted.
- `ready`: combinational.
  - IDLE: `ready = ~(wr_en|rd_en)`.
  - LOW/HIGH: `ready = 0`.
  - DONE: `ready = 1`.
- Writes never modify `read_data`.

## Timing
- Reset values: state IDLE, counter 0, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `addr_err`=0.
- Request first visible in IDLE at cycle 0:
  - `ready` low for cycles 0 through 2·(WAIT_CYCLES+1).
  - `ready` high in DONE at cycle 2·(WAIT_CYCLES+1)+1.
  - Default WAIT_CYCLES=1: 5 frozen cycles, DONE on cycle 5.
- Back-to-back requests: the next instruction's request is seen in IDLE the cycle after DONE, so there is one idle cycle between accesses.
- Reset mid-access: return immediately to reset values. A partially written word is left as-is; no completion is signalled.
- Request deasserted mid-access (only possible via reset/flush): ignored; the sequence completes.

## Configuration
- `SRAM_CTRL_ADDR_CHECK_EN` defined:
  - An address below ADDR_BASE, or with word ≥ 2^(SRAM_AW−1), goes IDLE → DONE directly.
  - No SRAM strobe is issued.
  - `read_data` is set to 0 for reads.
  - `addr_err=1` during DONE only.
- Undefined: no check; the address wraps modulo the SRAM size and `addr_err` is tied 0.

## Structure
- Package `mem_sram_pkg`: state enum (IDLE, LOW, HIGH, DONE), half-select constants, default WAIT_CYCLES/ADDR_BASE.
- One sub-module, `sram_phase_counter`: a clear-on-entry counter producing a `last` flag at WAIT_CYCLES.
- Tri-state pad is instantiated at top level from `sram_dq_out`/`sram_dq_oe`.

## Test plan
- Store `address`=1024, `write_data`=0xDEADBEEF, W=1 → `sram_addr` 0 gets 0xBEEF, then `sram_addr` 1 gets 0xDEAD; `sram_we_n` low one cycle per phase; `ready` low 5 cycles.
- Load from 1024 after that store, SRAM model returns the stored halves → `read_data`=0xDEADBEEF in DONE; `ready`=1 for exactly one cycle, then IDLE.
- `wr_en` and `rd_en` both high, address 1028 → write to `sram_addr` 2/3 performed; `read_data` unchanged.
- Assert `reset` in HIGH of a load → `sram_we_n`=1, `read_data`=0, state IDLE next cycle; a new load completes normally.
- Two consecutive loads 1032, 1036 held until `ready` → each DONE yields the correct word, exactly one access per request, one IDLE cycle between them.
- With `SRAM_CTRL_ADDR_CHECK_EN`, load from 512 → DONE on cycle 1, `addr_err`=1, `read_data`=0, no SRAM activity.

Source files
------------

// File: rtl/mem_sram_pkg.sv
// Shared definitions for the MEM-stage SRAM access sequencer.
//   state_e          : sequencer states (IDLE, LOW, HIGH, DONE)
//   HALF_LO/HALF_HI  : SRAM address LSB selecting the low/high half-word
//   DEF_*            : default parameter values for mem_sram_ctrl
package mem_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int unsigned DEF_WAIT_CYCLES = 1;
  localparam int unsigned DEF_ADDR_BASE   = 1024;
  localparam int unsigned DEF_SRAM_AW     = 18;

endpackage

// File: rtl/sram_phase_counter.sv
// Phase timer for one half-word SRAM access.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : clear to 0 (asserted on the cycle a phase is entered)
//   en_i       : count while a phase is active
//   last_o     : high on the final phase cycle (count == WAIT_CYCLES)
module sram_phase_counter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(WAIT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !last_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory sequencer: one 32-bit load/store becomes two 16-bit
// accesses (low half, then high half) on an external asynchronous SRAM.
// ready low freezes the pipeline while an access is in flight.
//   clk, reset          : clock, asynchronous active-high reset
//   wr_en, rd_en        : store / load request (store wins if both)
//   address, write_data : byte address and store data
//   read_data           : load result, held until the next load completes
//   ready               : low = freeze pipeline
//   addr_err            : out-of-range flag (DONE only, check build)
//   sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n : SRAM pins
// Optional macro SRAM_CTRL_ADDR_CHECK_EN: out-of-range addresses skip the
// SRAM and complete immediately with addr_err; otherwise addresses wrap.
module mem_sram_ctrl
  import mem_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned WW = SRAM_AW - 1;

  state_e        state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          is_wr_q, is_wr_d;

  logic          req, in_phase, phase_clr, phase_last;
  logic [31:0]   offset;
  logic [WW-1:0] word_in;

  assign req      = wr_en | rd_en;
  assign offset   = address - ADDR_BASE;
  assign word_in  = offset[SRAM_AW:2];
  assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);
  // The counter restarts on every state change, i.e. on entry to LOW and HIGH.
  assign phase_clr = (state_d != state_q);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic       err_q, err_d, out_of_range;
  logic [1:0] unused_offset;
  assign out_of_range  = (address < ADDR_BASE) || (|offset[31:SRAM_AW+1]);
  assign unused_offset = offset[1:0];
  assign addr_err      = err_q && (state_q == ST_DONE);
`else
  logic [32-SRAM_AW:0] unused_offset;
  assign unused_offset = {offset[31:SRAM_AW+1], offset[1:0]};
  assign addr_err      = 1'b0;
`endif

  sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (phase_clr),
    .en_i   (in_phase),
    .last_o (phase_last)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    is_wr_d = is_wr_q;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: if (req) begin
        word_d  = word_in;
        wdata_d = write_data;
        is_wr_d = wr_en;
        state_d = ST_LOW;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        err_d = out_of_range;
        if (out_of_range) begin
          state_d = ST_DONE;
          if (!wr_en) rdata_d = '0;
        end
`endif
      end
      ST_LOW: if (phase_last) begin
        if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
        state_d = ST_HIGH;
      end
      ST_HIGH: if (phase_last) begin
        if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // The request still visible here is the one just completed.
        state_d = ST_IDLE;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        err_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_wr_q <= is_wr_d;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Pin drive: write strobe on all but the last phase cycle, which holds
  // address and data stable after we_n rises.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (in_phase) begin
      sram_addr = {word_q, (state_q == ST_HIGH) ? HALF_HI : HALF_LO};
      if (is_wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
        sram_we_n   = phase_last;
      end
    end
  end

  always_comb begin
    ready = 1'b1;
    unique case (state_q)
      ST_IDLE: ready = ~req;
      ST_LOW,
      ST_HIGH: ready = 1'b0;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  assign read_data = rdata_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
module tb_mem_sram_ctrl;

  localparam int unsigned W    = 1;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, rd_en;
  logic [31:0]   address, write_data, read_data;
  logic          ready, addr_err;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  mem_sram_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(BASE), .SRAM_AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .addr_err(addr_err), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM (half-word array) and strobe counter.
  bit [15:0]   sram [0:(1<<AW)-1];
  int unsigned strobes = 0;
  always @(posedge clk) begin
    if (!sram_we_n) begin
      sram[sram_addr] <= sram_dq_out;
      strobes <= strobes + 1;
    end
  end
  assign sram_dq_in = sram[sram_addr];

  // Reference model: 32-bit words indexed by word number.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd = '0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request (held until ready) and check the completion.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    int          n;
    int unsigned s0;
    bit          oor;
    int          widx;
    int unsigned exp_lat;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    s0  = strobes;
    oor = 1'b0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    oor = (a < BASE) || (((a - BASE) >> 2) >= (32'd1 << (AW - 1)));
`endif
    widx    = int'(((a - BASE) >> 2) & ((32'd1 << (AW - 1)) - 1));
    exp_lat = oor ? 1 : 2 * (W + 1) + 1;
    n = 0;
    @(negedge clk);
    while (!ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("latency", n, exp_lat);
    if (oor) begin
      if (!w) exp_rd = '0;
    end else if (w) begin
      ref_mem[widx] = d;
    end else begin
      exp_rd = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
    end
    check("read_data", read_data, exp_rd);
    check("addr_err", {31'd0, addr_err}, {31'd0, oor});
    check("strobes", strobes - s0, (w && !oor) ? 2 * W : 0);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd1);
    check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    check("idle_oe", {31'd0, sram_dq_oe}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    #12;
    check("rst_read_data", read_data, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_sram_addr", {14'd0, sram_addr}, 32'h0);
    check("rst_dq_out", {16'd0, sram_dq_out}, 32'h0);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Store then load at the base address.
    access(1, 0, 32'd1024, 32'hDEADBEEF);
    go_idle();
    check("sram0", {16'd0, sram[0]}, 32'h0000BEEF);
    check("sram1", {16'd0, sram[1]}, 32'h0000DEAD);
    access(0, 1, 32'd1024, 32'h0);
    go_idle();

    // Both requests high: the store wins, read_data untouched.
    access(1, 1, 32'd1028, 32'h12345678);
    go_idle();
    check("sram2", {16'd0, sram[2]}, 32'h00005678);
    check("sram3", {16'd0, sram[3]}, 32'h00001234);

    // Reset while in the HIGH phase of a load.
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1024;
    repeat (3) @(posedge clk);
    #1;
    check("high_addr", {14'd0, sram_addr}, 32'd1);
    check("high_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1; rd_en = 1'b0;
    #1;
    check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("mid_rst_read_data", read_data, 32'h0);
    check("mid_rst_addr", {14'd0, sram_addr}, 32'h0);
    exp_rd = '0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    access(0, 1, 32'd1024, 32'h0);
    go_idle();

    // Back-to-back loads.
    access(1, 0, 32'd1032, 32'hA5A51111);
    access(1, 0, 32'd1036, 32'h5A5A2222);
    go_idle();
    access(0, 1, 32'd1032, 32'h0);
    access(0, 1, 32'd1036, 32'h0);
    go_idle();

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    access(0, 1, 32'd512, 32'h0);
    go_idle();
`endif

    // Randomized traffic over a small window.
    for (int i = 0; i < 30; i++) begin
      bit          w;
      logic [31:0] a;
      w = ($urandom_range(0, 1) == 1);
      a = BASE + 4 * $urandom_range(0, 15);
      access(w, !w, a, $urandom);
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
